// File: rtl/inst_cache_if.sv
// Fetch/memory bus of the instruction cache.
//   slave  : the cache side (inst_cache uses this modport)
//   master : the fetch stage plus instruction memory driving the cache
// Signals:
//   pc_valid, pc, flush     fetch request, word address, invalidate-all
//   inst, inst_valid, stall instruction return and fetch stall
//   mem_req, mem_addr       block request to memory (block-aligned word address)
//   mem_block               16-word block from memory, word 0 in the top bits
//   hit_count, miss_count   performance counters
interface inst_cache_if #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 16
);
  logic                            pc_valid;
  logic [WORD_SIZE-1:0]            pc;
  logic                            flush;
  logic [WORD_SIZE-1:0]            inst;
  logic                            inst_valid;
  logic                            stall;
  logic                            mem_req;
  logic [WORD_SIZE-1:0]            mem_addr;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_block;
  logic [31:0]                     hit_count;
  logic [31:0]                     miss_count;

  modport slave (
    input  pc_valid, pc, flush, mem_block,
    output inst, inst_valid, stall, mem_req, mem_addr, hit_count, miss_count
  );

  modport master (
    output pc_valid, pc, flush, mem_block,
    input  inst, inst_valid, stall, mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache.
// Hits return the instruction combinationally in the same cycle. A miss latches
// the block address, raises mem_req for MISS_LATENCY cycles, then writes the
// whole 16-word line in one FILL cycle; the retried lookup then hits.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    inst_cache_if.slave (fetch request/response, memory block port, counters)
module inst_cache #(
  parameter int WORD_SIZE    = 32,
  parameter int BLOCK_SIZE   = 16,
  parameter int INDEX_BITS   = 3,
  parameter int MISS_LATENCY = 4
) (
  input logic         clk,
  input logic         rst_n,
  inst_cache_if.slave bus
);
  localparam int OFFSET_BITS = 4;
  localparam int LINES       = 1 << INDEX_BITS;
  localparam int TAG_BITS    = WORD_SIZE - OFFSET_BITS - INDEX_BITS;
  localparam int BLK_BITS    = WORD_SIZE - OFFSET_BITS;
  localparam logic [7:0] WAIT_INIT = 8'(MISS_LATENCY - 1);

  typedef enum logic [1:0] {LOOKUP, MISS_WAIT, FILL} state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [WORD_SIZE-1:0]  data_mem [LINES][BLOCK_SIZE];
  logic [BLK_BITS-1:0]   miss_blk;
  logic [7:0]            wait_cnt;
  logic [31:0]           hit_cnt;
  logic [31:0]           miss_cnt;
  logic                  mem_req_q;

  logic [OFFSET_BITS-1:0] pc_offset;
  logic [INDEX_BITS-1:0]  pc_index;
  logic [TAG_BITS-1:0]    pc_tag;
  logic [INDEX_BITS-1:0]  miss_index;
  logic [TAG_BITS-1:0]    miss_tag;
  logic                   hit;
  logic                   lookup_hit;
  logic                   fill_we;

  assign pc_offset  = bus.pc[OFFSET_BITS-1:0];
  assign pc_index   = bus.pc[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign pc_tag     = bus.pc[WORD_SIZE-1:OFFSET_BITS+INDEX_BITS];
  assign miss_index = miss_blk[INDEX_BITS-1:0];
  assign miss_tag   = miss_blk[BLK_BITS-1:INDEX_BITS];

  assign hit = valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  // A flush in the same cycle suppresses the hit so no stale word is delivered.
  assign lookup_hit = (state == LOOKUP) && bus.pc_valid && !bus.flush && hit;

  assign bus.inst       = data_mem[pc_index][pc_offset];
  assign bus.inst_valid = lookup_hit;
  assign bus.stall      = bus.pc_valid && !lookup_hit;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = {miss_blk, {OFFSET_BITS{1'b0}}};
  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;

  // Control FSM. mem_req is registered and set/cleared on the state transitions
  // so it is high exactly for the MISS_WAIT cycles.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOOKUP;
      valid     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      wait_cnt  <= '0;
      mem_req_q <= 1'b0;
      miss_blk  <= '0;
    end else if (bus.flush) begin
      // Any in-flight miss is dropped; the line is never written.
      valid     <= '0;
      state     <= LOOKUP;
      mem_req_q <= 1'b0;
    end else begin
      case (state)
        LOOKUP: begin
          if (bus.pc_valid) begin
            if (hit) begin
              hit_cnt <= hit_cnt + 32'd1;
            end else begin
              miss_blk  <= bus.pc[WORD_SIZE-1:OFFSET_BITS];
              miss_cnt  <= miss_cnt + 32'd1;
              wait_cnt  <= WAIT_INIT;
              mem_req_q <= 1'b1;
              state     <= MISS_WAIT;
            end
          end
        end
        MISS_WAIT: begin
          if (wait_cnt == 8'd0) begin
            mem_req_q <= 1'b0;
            state     <= FILL;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        FILL: begin
          valid[miss_index] <= 1'b1;
          state             <= LOOKUP;
        end
        default: state <= LOOKUP;
      endcase
    end
  end

  assign fill_we = (state == FILL) && !bus.flush;

  // Line storage. Word k of the memory block sits in the top-down slot k.
  // NOTE: data and tag arrays carry no reset; the valid flops alone decide
  // whether their contents are ever used, which keeps them plain RAM.
  always_ff @(posedge clk) begin
    if (rst_n && fill_we) begin
      tag_mem[miss_index] <= miss_tag;
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        data_mem[miss_index][k] <= bus.mem_block[(BLOCK_SIZE-k)*WORD_SIZE-1 -: WORD_SIZE];
      end
    end
  end
endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache. Two instances share the fetch stimulus:
// one built with MISS_LATENCY=4 and one with MISS_LATENCY=1. Each has its own
// memory model and its own behavioural cache model; a compare process checks
// every output of both against their models on every negedge. Directed
// sequences with hand-computed expectations run first, then random traffic.
module tb_inst_cache;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_valid;
  logic [31:0] pc;
  logic        flush;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  inst_cache_if #(.WORD_SIZE(32), .BLOCK_SIZE(16)) bus4 ();
  inst_cache_if #(.WORD_SIZE(32), .BLOCK_SIZE(16)) bus1 ();

  inst_cache #(.MISS_LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  inst_cache #(.MISS_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus4.pc_valid = pc_valid;
  assign bus4.pc       = pc;
  assign bus4.flush    = flush;
  assign bus1.pc_valid = pc_valid;
  assign bus1.pc       = pc;
  assign bus1.flush    = flush;

  // Instruction memory content: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [511:0] block_of(input logic [31:0] a);
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[(16-k)*32-1 -: 32] = mem_word({a[31:4], 4'(k)});
    return b;
  endfunction

  // Memory side: latches the requested address while mem_req is high.
  logic [31:0] lat4 = '0, lat1 = '0;
  always @(posedge clk) begin
    if (bus4.mem_req) lat4 <= bus4.mem_addr;
    if (bus1.mem_req) lat1 <= bus1.mem_addr;
  end
  assign bus4.mem_block = block_of(lat4);
  assign bus1.mem_block = block_of(lat1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // line_blk holds the block number resident in each line (-1 = empty).
  // busy counts cycles until lookups are accepted again after a miss:
  // lat+1 .. 2 are the memory-request cycles, 1 is the fill cycle.
  int          line_blk [2][8];
  int          busy     [2];
  int          miss_blk [2];
  logic [31:0] hits     [2];
  logic [31:0] misses   [2];
  int          lat_of   [2] = '{4, 1};

  logic [31:0] o_inst [2], o_addr [2], o_hc [2], o_mc [2];
  logic        o_iv [2], o_st [2], o_req [2];
  always_comb begin
    o_inst[0] = bus4.inst;       o_inst[1] = bus1.inst;
    o_iv[0]   = bus4.inst_valid; o_iv[1]   = bus1.inst_valid;
    o_st[0]   = bus4.stall;      o_st[1]   = bus1.stall;
    o_req[0]  = bus4.mem_req;    o_req[1]  = bus1.mem_req;
    o_addr[0] = bus4.mem_addr;   o_addr[1] = bus1.mem_addr;
    o_hc[0]   = bus4.hit_count;  o_hc[1]   = bus1.hit_count;
    o_mc[0]   = bus4.miss_count; o_mc[1]   = bus1.miss_count;
  end

  task automatic model_clear(input int d);
    for (int i = 0; i < 8; i++) line_blk[d][i] = -1;
    busy[d] = 0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      miss_blk[d] = 0;
      hits[d]     = '0;
      misses[d]   = '0;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        int  blk, idx;
        logic eh;
        blk = int'(pc >> 4);
        idx = blk % 8;
        eh  = pc_valid && (busy[d] == 0) && !flush && (line_blk[d][idx] == blk);
        check($sformatf("d%0d_inst_valid", d), 32'(o_iv[d]), 32'(eh));
        check($sformatf("d%0d_stall", d), 32'(o_st[d]), 32'(pc_valid && !eh));
        check($sformatf("d%0d_mem_req", d), 32'(o_req[d]), 32'(busy[d] >= 2));
        if (busy[d] >= 2) check($sformatf("d%0d_mem_addr", d), o_addr[d], 32'(miss_blk[d] * 16));
        if (eh) check($sformatf("d%0d_inst", d), o_inst[d], mem_word(pc));
        check($sformatf("d%0d_hit_count", d), o_hc[d], hits[d]);
        check($sformatf("d%0d_miss_count", d), o_mc[d], misses[d]);
        // advance to the state after the coming clock edge
        if (!rst_n) begin
          model_clear(d);
          miss_blk[d] = 0;
          hits[d]     = '0;
          misses[d]   = '0;
        end else if (flush) begin
          model_clear(d);
        end else if (busy[d] > 0) begin
          if (busy[d] == 1) line_blk[d][miss_blk[d] % 8] = miss_blk[d];
          busy[d]--;
        end else if (pc_valid) begin
          if (line_blk[d][idx] == blk) hits[d]++;
          else begin
            misses[d]++;
            miss_blk[d] = blk;
            busy[d]     = lat_of[d] + 1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic f);
    pc_valid = v;
    pc       = p;
    flush    = f;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Waits (bounded) until dut4 reports a hit; leaves time at that negedge.
  task automatic wait_hit(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus4.inst_valid && n < 20) begin
      next_cycle();
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus4.inst_valid), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_inst_valid", 32'(bus4.inst_valid), 32'd0);
    check("reset_mem_req", 32'(bus4.mem_req), 32'd0);
    check("reset_mem_addr", bus4.mem_addr, 32'h0);
    check("reset_miss_count", bus4.miss_count, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // 1: cold miss on 0x23
    drive(1'b1, 32'h23, 1'b0);
    @(negedge clk);
    check("t1_stall", 32'(bus4.stall), 32'd1);
    check("t1_no_hit", 32'(bus4.inst_valid), 32'd0);
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("t1_mem_req", 32'(bus4.mem_req), 32'd1);
      check("t1_mem_addr", bus4.mem_addr, 32'h20);
      next_cycle();
    end
    @(negedge clk);
    check("t1_fill_req_low", 32'(bus4.mem_req), 32'd0);
    check("t1_fill_stall", 32'(bus4.stall), 32'd1);
    next_cycle();
    @(negedge clk);
    check("t1_hit_at_6", 32'(bus4.inst_valid), 32'd1);
    check("t1_inst", bus4.inst, mem_word(32'h23));
    next_cycle();
    drive(1'b0, 32'h23, 1'b0);
    @(negedge clk);
    check("t1_hit_count", bus4.hit_count, 32'd1);
    check("t1_miss_count", bus4.miss_count, 32'd1);
    next_cycle();

    // 2: spatial hits over the whole block
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h20 + 32'(i), 1'b0);
      @(negedge clk);
      check("t2_hit", 32'(bus4.inst_valid), 32'd1);
      check("t2_inst", bus4.inst, mem_word(32'h20 + 32'(i)));
      check("t2_no_req", 32'(bus4.mem_req), 32'd0);
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t2_hit_count", bus4.hit_count, 32'd17);
    next_cycle();

    // 3: conflict on index 0
    do_reset();
    drive(1'b1, 32'h05, 1'b0);
    wait_hit("t3_fill_05");
    next_cycle();
    drive(1'b1, 32'h85, 1'b0);
    @(negedge clk);
    check("t3_miss_85", 32'(bus4.inst_valid), 32'd0);
    wait_hit("t3_fill_85");
    check("t3_inst_85", bus4.inst, mem_word(32'h85));
    next_cycle();
    drive(1'b1, 32'h05, 1'b0);
    @(negedge clk);
    check("t3_miss_05_again", 32'(bus4.inst_valid), 32'd0);
    wait_hit("t3_refill_05");
    next_cycle();
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t3_miss_count", bus4.miss_count, 32'd3);
    check("t3_hit_count", bus4.hit_count, 32'd3);
    next_cycle();

    // 4: flush in the second MISS_WAIT cycle
    drive(1'b1, 32'h40, 1'b0);
    next_cycle();
    @(negedge clk);
    check("t4_wait1_req", 32'(bus4.mem_req), 32'd1);
    next_cycle();
    flush = 1'b1;
    next_cycle();
    drive(1'b0, 32'h40, 1'b0);
    @(negedge clk);
    check("t4_abort_req", 32'(bus4.mem_req), 32'd0);
    check("t4_miss_count", bus4.miss_count, 32'd4);
    next_cycle();
    drive(1'b1, 32'h40, 1'b0);
    @(negedge clk);
    check("t4_no_line", 32'(bus4.inst_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t4_new_miss", bus4.miss_count, 32'd5);
    wait_hit("t4_fill_40");
    next_cycle();

    // 5: reset while filling
    drive(1'b1, 32'h00, 1'b0);
    for (int c = 0; c < 5; c++) next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 32'h00, 1'b0);
    @(negedge clk);
    check("t5_hit_count", bus4.hit_count, 32'd0);
    check("t5_miss_count", bus4.miss_count, 32'd0);
    check("t5_mem_req", 32'(bus4.mem_req), 32'd0);
    check("t5_mem_addr", bus4.mem_addr, 32'h0);
    next_cycle();
    drive(1'b1, 32'h00, 1'b0);
    @(negedge clk);
    check("t5_cold", 32'(bus4.inst_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t5_miss_count_after", bus4.miss_count, 32'd1);
    wait_hit("t5_fill_00");
    next_cycle();

    // 6: MISS_LATENCY=1 instance, word 15 from the low bits of the block
    do_reset();
    drive(1'b1, 32'h1F, 1'b0);
    @(negedge clk);
    check("t6_miss", 32'(bus1.inst_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t6_req", 32'(bus1.mem_req), 32'd1);
    check("t6_addr", bus1.mem_addr, 32'h10);
    next_cycle();
    @(negedge clk);
    check("t6_fill", 32'(bus1.inst_valid), 32'd0);
    check("t6_block_low", bus1.mem_block[31:0], mem_word(32'h1F));
    next_cycle();
    @(negedge clk);
    check("t6_hit_at_3", 32'(bus1.inst_valid), 32'd1);
    check("t6_word15", bus1.inst, mem_word(32'h1F));
    next_cycle();

    // random traffic, checked by the models
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      flush    = ($urandom_range(0, 39) == 0);
      pc_valid = ($urandom_range(0, 3) != 0);
      if (!bus4.stall || $urandom_range(0, 9) == 0) begin
        int r = $urandom_range(0, 9);
        if (r < 6)      pc = (pc + 32'd1) & 32'hFFF;
        else if (r < 8) pc = 32'($urandom_range(0, 255));
        else            pc = 32'($urandom_range(0, 4095));
      end
      next_cycle();
    end
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
